// File: rtl/ddr2_clk_rst_seq_if.sv
// Control/status bundle between the DDR2 clock/reset sequencer and its surroundings.
// The sequencer uses the slave modport; the pin/controller side uses master.
interface ddr2_clk_rst_seq_if;
    logic       sys_rst_req;
    logic       pll_locked;
    logic       idelay_ctrl_rdy;
    logic       pll_rst;
    logic       idelayctrl_rst;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [1:0] retry_cnt;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

    modport master (
        output sys_rst_req, pll_locked, idelay_ctrl_rdy,
        input  pll_rst, idelayctrl_rst, ready, fault, lock_lost,
               retry_cnt, state, lock_loss_cnt
    );

    modport slave (
        input  sys_rst_req, pll_locked, idelay_ctrl_rdy,
        output pll_rst, idelayctrl_rst, ready, fault, lock_lost,
               retry_cnt, state, lock_loss_cnt
    );
endinterface

// File: rtl/ddr2_clk_rst_seq.sv
// DDR2 PLL / IDELAYCTRL bring-up sequencer on the 200 MHz reference clock.
// Define DDR2_SEQ_LOSS_CNT_EN to build the saturating lock-loss event counter.
module ddr2_clk_rst_seq #(
    parameter int PLL_RST_CYC  = 16,
    parameter int IDLY_RST_CYC = 12,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int IDLY_TIMEOUT = 4095,
    parameter int SETTLE_CYC   = 25,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clk200,
    input  logic              rst200,
    ddr2_clk_rst_seq_if.slave bus
);

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        RST_IDLY  = 3'd2,
        WAIT_IDLY = 3'd3,
        SETTLE    = 3'd4,
        RUN       = 3'd5,
        FAULT     = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [1:0]  retry_reg, retry_next;
    logic        lost_next;
    logic        fail_now;
    logic        pll_rst_reg, idly_rst_reg, ready_reg, fault_reg, lost_reg;
    logic [1:0]  async_in;
    logic [1:0]  sync_s;
    logic        lock_s, rdy_s;

    assign async_in = {bus.idelay_ctrl_rdy, bus.pll_locked};

    // Two-flop synchronizers, bit 0 = PLL LOCKED, bit 1 = IDELAYCTRL RDY.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg, s2_reg;
            always_ff @(posedge clk200) begin
                if (rst200) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= async_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_s[gi] = s2_reg;
        end
    endgenerate

    assign lock_s = sync_s[0];
    assign rdy_s  = sync_s[1];

    function automatic logic [15:0] reload(input state_t st);
        case (st)
            RST_PLL:   reload = 16'(PLL_RST_CYC - 1);
            WAIT_LOCK: reload = 16'(LOCK_TIMEOUT - 1);
            RST_IDLY:  reload = 16'(IDLY_RST_CYC - 1);
            WAIT_IDLY: reload = 16'(IDLY_TIMEOUT - 1);
            SETTLE:    reload = 16'(SETTLE_CYC - 1);
            default:   reload = 16'd0;
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        lost_next  = 1'b0;
        fail_now   = 1'b0;
        if (bus.sys_rst_req) begin
            state_next = RST_PLL;
            retry_next = 2'd0;
        end else begin
            case (state_reg)
                RST_PLL:   if (cnt_reg == 16'd0) state_next = WAIT_LOCK;
                // Lock is tested before the timeout so success wins a tie.
                WAIT_LOCK: if (lock_s) state_next = RST_IDLY;
                           else if (cnt_reg == 16'd0) fail_now = 1'b1;
                RST_IDLY:  if (!lock_s) fail_now = 1'b1;
                           else if (cnt_reg == 16'd0) state_next = WAIT_IDLY;
                WAIT_IDLY: if (!lock_s) fail_now = 1'b1;
                           else if (rdy_s) state_next = SETTLE;
                           else if (cnt_reg == 16'd0) fail_now = 1'b1;
                SETTLE:    if (!(lock_s && rdy_s)) fail_now = 1'b1;
                           else if (cnt_reg == 16'd0) state_next = RUN;
                RUN:       if (!(lock_s && rdy_s)) begin
                               state_next = RST_PLL;
                               lost_next  = 1'b1;
                           end
                FAULT:     state_next = FAULT;
                default:   state_next = RST_PLL;
            endcase
        end

        if (fail_now) begin
            if (retry_reg == 2'(MAX_RETRY)) begin
                state_next = FAULT;
            end else begin
                retry_next = retry_reg + 2'd1;
                state_next = RST_PLL;
            end
        end

        if (state_next == RUN && state_reg != RUN) retry_next = 2'd0;

        // Any state entry (or a held restart request) reloads the shared counter.
        if (bus.sys_rst_req || state_next != state_reg) cnt_next = reload(state_next);
        else if (cnt_reg != 16'd0)                     cnt_next = cnt_reg - 16'd1;
        else                                           cnt_next = cnt_reg;
    end

    always_ff @(posedge clk200) begin
        if (rst200) begin
            state_reg    <= RST_PLL;
            cnt_reg      <= reload(RST_PLL);
            retry_reg    <= 2'd0;
            pll_rst_reg  <= 1'b1;
            idly_rst_reg <= 1'b1;
            ready_reg    <= 1'b0;
            fault_reg    <= 1'b0;
            lost_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            retry_reg    <= retry_next;
            pll_rst_reg  <= (state_next == RST_PLL) || (state_next == FAULT);
            idly_rst_reg <= state_next inside {RST_PLL, WAIT_LOCK, RST_IDLY, FAULT};
            ready_reg    <= (state_next == RUN);
            fault_reg    <= (state_next == FAULT);
            lost_reg     <= lost_next;
        end
    end

`ifdef DDR2_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_reg;

    // Survives sys_rst_req on purpose: it records history across restarts.
    always_ff @(posedge clk200) begin
        if (rst200)
            loss_cnt_reg <= 8'h00;
        else if (lost_next && loss_cnt_reg != 8'hFF)
            loss_cnt_reg <= loss_cnt_reg + 8'h01;
    end

    assign bus.lock_loss_cnt = loss_cnt_reg;
`else
    assign bus.lock_loss_cnt = 8'h00;
`endif

    assign bus.state          = state_reg;
    assign bus.pll_rst        = pll_rst_reg;
    assign bus.idelayctrl_rst = idly_rst_reg;
    assign bus.ready          = ready_reg;
    assign bus.fault          = fault_reg;
    assign bus.lock_lost      = lost_reg;
    assign bus.retry_cnt      = retry_reg;

endmodule

// File: tb/tb_ddr2_clk_rst_seq.sv
// Randomized bench for ddr2_clk_rst_seq: a phase/elapsed-time model predicts every cycle's
// outputs into a queue, and a separate monitor compares them against the DUT.
module tb_ddr2_clk_rst_seq;

    localparam int P_PLL  = 4;
    localparam int P_IDLY = 3;
    localparam int P_LTO  = 20;
    localparam int P_ITO  = 10;
    localparam int P_SET  = 5;
    localparam int P_MAXR = 2;
    localparam int NCYC   = 4000;

    logic clk200 = 1'b0;
    logic rst200 = 1'b1;

    ddr2_clk_rst_seq_if bus();

    ddr2_clk_rst_seq #(
        .PLL_RST_CYC (P_PLL),
        .IDLY_RST_CYC(P_IDLY),
        .LOCK_TIMEOUT(P_LTO),
        .IDLY_TIMEOUT(P_ITO),
        .SETTLE_CYC  (P_SET),
        .MAX_RETRY   (P_MAXR)
    ) dut (
        .clk200(clk200),
        .rst200(rst200),
        .bus   (bus)
    );

    always #5 clk200 = ~clk200;

    typedef struct packed {
        logic [2:0] state;
        logic       pll_rst;
        logic       idly_rst;
        logic       ready;
        logic       fault;
        logic       lost;
        logic [1:0] retry;
        logic [7:0] llc;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model: phase number, cycles spent in the phase, and pin history for the 2-cycle sync lag.
    int       m_phase   = 0;
    int       m_elapsed = 0;
    int       m_retry   = 0;
    int       m_llc     = 0;
    bit       m_lost    = 1'b0;
    bit [1:0] lock_hist = 2'b00;
    bit [1:0] rdy_hist  = 2'b00;

    function automatic obs_t model_obs();
        obs_t o;
        o.state    = 3'(m_phase);
        o.pll_rst  = (m_phase == 0) || (m_phase == 6);
        o.idly_rst = (m_phase <= 2) || (m_phase == 6);
        o.ready    = (m_phase == 5);
        o.fault    = (m_phase == 6);
        o.lost     = m_lost;
        o.retry    = 2'(m_retry);
        o.llc      = 8'(m_llc);
        return o;
    endfunction

    task automatic model_step(input bit rst, input bit req, input bit lp, input bit rp);
        bit ls, rs, fail;
        int nxt;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_retry = 0; m_llc = 0; m_lost = 1'b0;
            lock_hist = 2'b00; rdy_hist = 2'b00;
            return;
        end
        ls = lock_hist[1];
        rs = rdy_hist[1];
        lock_hist = {lock_hist[0], lp};
        rdy_hist  = {rdy_hist[0], rp};
        fail   = 1'b0;
        nxt    = m_phase;
        m_lost = 1'b0;
        if (req) begin
            nxt = 0;
            m_retry = 0;
        end else begin
            case (m_phase)
                0: if (m_elapsed + 1 >= P_PLL) nxt = 1;
                1: if (ls) nxt = 2; else if (m_elapsed + 1 >= P_LTO) fail = 1'b1;
                2: if (!ls) fail = 1'b1; else if (m_elapsed + 1 >= P_IDLY) nxt = 3;
                3: if (!ls) fail = 1'b1; else if (rs) nxt = 4;
                   else if (m_elapsed + 1 >= P_ITO) fail = 1'b1;
                4: if (!(ls && rs)) fail = 1'b1; else if (m_elapsed + 1 >= P_SET) nxt = 5;
                5: if (!(ls && rs)) begin nxt = 0; m_lost = 1'b1; end
                default: ;
            endcase
        end
        if (fail) begin
            if (m_retry == P_MAXR) nxt = 6;
            else begin m_retry++; nxt = 0; end
        end
        if (nxt == 5 && m_phase != 5) m_retry = 0;
        m_elapsed = (req || nxt != m_phase) ? 0 : m_elapsed + 1;
        m_phase   = nxt;
`ifdef DDR2_SEQ_LOSS_CNT_EN
        if (m_lost && m_llc < 255) m_llc++;
`endif
    endtask

    // Monitor: one comparison per clock once predictions are queued.
    obs_t mon_exp, mon_act;
    initial begin
        forever begin
            @(posedge clk200);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act.state    = bus.state;
                mon_act.pll_rst  = bus.pll_rst;
                mon_act.idly_rst = bus.idelayctrl_rst;
                mon_act.ready    = bus.ready;
                mon_act.fault    = bus.fault;
                mon_act.lost     = bus.lock_lost;
                mon_act.retry    = bus.retry_cnt;
                mon_act.llc      = bus.lock_loss_cnt;
                n_vec++;
                if (mon_act !== mon_exp) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got st=%0d prst=%b irst=%b rdy=%b flt=%b lost=%b rty=%0d llc=%0d need st=%0d prst=%b irst=%b rdy=%b flt=%b lost=%b rty=%0d llc=%0d",
                             $time, mon_act.state, mon_act.pll_rst, mon_act.idly_rst, mon_act.ready,
                             mon_act.fault, mon_act.lost, mon_act.retry, mon_act.llc,
                             mon_exp.state, mon_exp.pll_rst, mon_exp.idly_rst, mon_exp.ready,
                             mon_exp.fault, mon_exp.lost, mon_exp.retry, mon_exp.llc);
                end
            end
        end
    end

    // Stimulus: emulated PLL/IDELAYCTRL that respond to the predicted reset outputs.
    obs_t cur;
    int   lock_age, rdy_age, lock_dly, rdy_dly;
    bit   rst_v, req_v, lp_v, rp_v;
    initial begin
        bus.sys_rst_req     = 1'b0;
        bus.pll_locked      = 1'b0;
        bus.idelay_ctrl_rdy = 1'b0;
        lock_age = 0; rdy_age = 0; lock_dly = 6; rdy_dly = 2;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk200);
            cur = model_obs();
            if (cur.pll_rst)  lock_age = 0; else if (lock_age < 1000) lock_age++;
            if (cur.idly_rst) rdy_age  = 0; else if (rdy_age  < 1000) rdy_age++;
            rst_v = (cyc < 4);
            req_v = 1'b0;
            if (cyc < 230) begin
                // Nominal bring-up, then lock held low until FAULT, then a one-cycle restart.
                lp_v = !cur.pll_rst && lock_age >= 6 && cyc < 100;
                rp_v = !cur.idly_rst && rdy_age >= 2;
            end else if (cyc == 230) begin
                req_v = 1'b1;
                lp_v = 1'b0;
                rp_v = 1'b0;
            end else begin
                if (cur.pll_rst)  lock_dly = ($urandom % 6 == 0) ? 100 : 1 + int'($urandom % 8);
                if (cur.idly_rst) rdy_dly  = ($urandom % 8 == 0) ? 100 : int'($urandom % 5);
                lp_v = !cur.pll_rst && lock_age >= lock_dly && ($urandom % 80 != 0);
                rp_v = !cur.idly_rst && rdy_age >= rdy_dly && ($urandom % 80 != 0);
                if (m_phase == 4 && $urandom % 6 == 0) rp_v = 1'b0;
                if ($urandom % 200 == 0) req_v = 1'b1;
                if (cur.fault && $urandom % 8 == 0) req_v = 1'b1;
                // Restart request landing on the WAIT_LOCK timeout edge.
                if (m_phase == 1 && m_elapsed == P_LTO - 1 && $urandom % 2 == 0) req_v = 1'b1;
                if ($urandom % 500 == 0) rst_v = 1'b1;
            end
            rst200              = rst_v;
            bus.sys_rst_req     = req_v;
            bus.pll_locked      = lp_v;
            bus.idelay_ctrl_rdy = rp_v;
            model_step(rst_v, req_v, lp_v, rp_v);
            exp_q.push_back(model_obs());
        end
        @(posedge clk200);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
